// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: the fetch push side (in_*) and the decode pop side (out_*).
// The queue binds to the slave modport and the fetch/decode side to the master modport.
interface fetch_queue_if #(
    parameter int EXC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic [EXC_W-1:0] in_except;
    logic             in_slot;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic [EXC_W-1:0] out_except;
    logic             out_slot;

    modport slave (
        input  in_valid, in_pc, in_instr, in_except, in_slot, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_except, out_slot
    );

    modport master (
        output in_valid, in_pc, in_instr, in_except, in_slot, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_except, out_slot
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer between fetch and decode, with flush.
// Define FETCH_QUEUE_BYPASS_EN to forward a push straight to decode when the queue is empty.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int EXC_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    fetch_queue_if.slave           fq,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [EXC_W-1:0] exc;
        logic             slot;
    } entry_t;

    entry_t      mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;

    entry_t in_ent, head, out_ent;
    logic   byp, push, pop, wr_en, rd_en;

    always_comb begin
        in_ent = '{pc: fq.in_pc, instr: fq.in_instr, exc: fq.in_except, slot: fq.in_slot};
        head   = mem_q[rd_ptr_q[AW-1:0]];

        // Equal index bits: the MSB tells a wrapped-full buffer from an empty one.
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

`ifdef FETCH_QUEUE_BYPASS_EN
        byp = empty && fq.in_valid && !flush && !rst;
`else
        byp = 1'b0;
`endif

        fq.in_ready  = !full && !flush && !rst;
        fq.out_valid = (!empty || byp) && !flush && !rst;

        out_ent        = byp ? in_ent : head;
        fq.out_pc      = out_ent.pc;
        fq.out_instr   = out_ent.instr;
        fq.out_except  = out_ent.exc;
        fq.out_slot    = out_ent.slot;

        push  = fq.in_valid && fq.in_ready;
        pop   = fq.out_valid && fq.out_ready;
        // A bypassed entry consumed in the same cycle never touches storage.
        wr_en = push && !(byp && pop);
        rd_en = pop && !byp;

        wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= in_ent;
    end

    assign count = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4): fill/drain, wrap streaming, flush, exception tags, bypass/latency, async reset.
module tb_fetch_queue;
    localparam logic [31:0] BASE = 32'hBFC0_0000;
    localparam logic [31:0] SBASE = 32'h9000_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [2:0] count;
    logic       full, empty;
    int         n_chk = 0;
    int         n_fail = 0;

    fetch_queue_if #(.EXC_W(8)) fq ();

    fetch_queue #(.DEPTH(4), .EXC_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .fq(fq),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [7:0] exc, input logic slot);
        fq.in_valid  = v;
        fq.in_pc     = pc;
        fq.in_instr  = ins;
        fq.in_except = exc;
        fq.in_slot   = slot;
    endtask

    initial begin
        set_in(1'b0, '0, '0, '0, 1'b0);
        fq.out_ready = 1'b0;

        // reset state
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_out_valid", 64'(fq.out_valid), 64'd0);
        chk("rst_in_ready", 64'(fq.in_ready), 64'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 64'(fq.in_ready), 64'd1);

        // fill to full, then drain in order
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, BASE + 32'(4 * i), 32'(i), 8'h00, 1'b0);
            #1;
`ifndef FETCH_QUEUE_BYPASS_EN
            if (i == 0) chk("latency_ov0", 64'(fq.out_valid), 64'd0);
`endif
            chk("fill_in_ready", 64'(fq.in_ready), 64'd1);
            tick();
        end
        set_in(1'b1, 32'hDEAD_BEEF, 32'h0, 8'h00, 1'b0);
        #1;
        chk("full_flag", 64'(full), 64'd1);
        chk("full_in_ready", 64'(fq.in_ready), 64'd0);
        chk("full_count", 64'(count), 64'd4);
        tick();
        #1;
        chk("full_no_push", 64'(count), 64'd4);
        fq.out_ready = 1'b1;
        #1;
        chk("full_pop_in_ready", 64'(fq.in_ready), 64'd0);
        chk("drain_pc0", 64'(fq.out_pc), 64'(BASE));
        tick();
        fq.in_valid = 1'b0;
        #1;
        chk("full_pop_count", 64'(count), 64'd3);
        for (int i = 1; i < 4; i++) begin
            chk("drain_valid", 64'(fq.out_valid), 64'd1);
            chk("drain_pc", 64'(fq.out_pc), 64'(BASE + 32'(4 * i)));
            tick();
            #1;
        end
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_out_valid", 64'(fq.out_valid), 64'd0);
        chk("drain_count", 64'(count), 64'd0);

        // streaming across pointer wrap
        fq.out_ready = 1'b0;
        set_in(1'b1, SBASE, 32'h0, 8'h00, 1'b0);
        tick();
        for (int k = 1; k <= 10; k++) begin
            set_in(1'b1, SBASE + 32'(4 * k), 32'(k), 8'h00, 1'b0);
            fq.out_ready = 1'b1;
            #1;
            chk("stream_pc", 64'(fq.out_pc), 64'(SBASE + 32'(4 * (k - 1))));
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_full", 64'(full), 64'd0);
            chk("stream_empty", 64'(empty), 64'd0);
            tick();
        end
        fq.in_valid = 1'b0;
        #1;
        chk("stream_last_pc", 64'(fq.out_pc), 64'(SBASE + 32'd40));
        tick();
        fq.out_ready = 1'b0;
        #1;
        chk("stream_end_empty", 64'(empty), 64'd1);

        // flush beats a simultaneous push and pop
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, BASE + 32'(16 * i), 32'(i), 8'h00, 1'b0);
            tick();
        end
        fq.out_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_pre_count", 64'(count), 64'd3);
        chk("flush_out_valid", 64'(fq.out_valid), 64'd0);
        chk("flush_in_ready", 64'(fq.in_ready), 64'd0);
        tick();
        flush = 1'b0;
        fq.in_valid = 1'b0;
        fq.out_ready = 1'b0;
        #1;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_ov_after", 64'(fq.out_valid), 64'd0);

        // exception tag and delay-slot flag ride along untouched
        set_in(1'b1, 32'hBFC0_0002, 32'h1234_5678, 8'h80, 1'b1);
        tick();
        fq.in_valid = 1'b0;
        fq.out_ready = 1'b1;
        #1;
        chk("exc_valid", 64'(fq.out_valid), 64'd1);
        chk("exc_pc", 64'(fq.out_pc), 64'hBFC0_0002);
        chk("exc_tag", 64'(fq.out_except), 64'h80);
        chk("exc_slot", 64'(fq.out_slot), 64'd1);
        chk("exc_instr", 64'(fq.out_instr), 64'h1234_5678);
        tick();
        fq.out_ready = 1'b0;
        #1;
        chk("exc_empty", 64'(empty), 64'd1);

        // empty-queue push: bypass or one-cycle latency
        set_in(1'b1, 32'h8000_0000, 32'hCAFE_0001, 8'h00, 1'b0);
        fq.out_ready = 1'b1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp_valid", 64'(fq.out_valid), 64'd1);
        chk("byp_pc", 64'(fq.out_pc), 64'h8000_0000);
        tick();
        fq.in_valid = 1'b0;
        fq.out_ready = 1'b0;
        #1;
        chk("byp_count", 64'(count), 64'd0);
        chk("byp_empty", 64'(empty), 64'd1);
`else
        chk("lat_valid_same", 64'(fq.out_valid), 64'd0);
        tick();
        fq.in_valid = 1'b0;
        fq.out_ready = 1'b0;
        #1;
        chk("lat_valid_next", 64'(fq.out_valid), 64'd1);
        chk("lat_pc", 64'(fq.out_pc), 64'h8000_0000);
        chk("lat_count", 64'(count), 64'd1);
        fq.out_ready = 1'b1;
        tick();
        fq.out_ready = 1'b0;
        #1;
        chk("lat_empty", 64'(empty), 64'd1);
`endif

        // asynchronous reset between edges
        set_in(1'b1, BASE, 32'h1, 8'h00, 1'b0);
        tick();
        fq.in_pc = BASE + 32'd4;
        tick();
        fq.in_valid = 1'b0;
        #1;
        chk("arst_pre_count", 64'(count), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_out_valid", 64'(fq.out_valid), 64'd0);
        chk("arst_in_ready", 64'(fq.in_ready), 64'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_rel_in_ready", 64'(fq.in_ready), 64'd1);
        chk("arst_rel_empty", 64'(empty), 64'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
